time_keeper: RTL

//  Real-time hh:mm:ss counter for the clock display path. Counts a 1 Hz tick

---
 rtl/time_keeper.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/time_keeper.sv
// Real-time hh:mm:ss counter driven by a prescaled 1 Hz tick and user set pulses.
// It publishes packed BCD time words with a one-cycle strobe, spaced at least HOLDOFF edges apart.
module time_keeper #(
  parameter int TICKS_PER_SEC = 50_000_000,
  parameter int HOLDOFF       = 100
) (
  input  logic        i_CLK,
  input  logic        i_RST,
  input  logic        i_INC_H,
  input  logic        i_INC_M,
  input  logic        i_CLR_S,
  output logic [23:0] o_DATA,
  output logic        o_VALID,
  output logic        o_TICK
);

  localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam int HW = $clog2(HOLDOFF + 1);
  localparam logic [PW-1:0] PRE_MAX     = PW'(TICKS_PER_SEC - 1);
  localparam logic [HW-1:0] HOLD_RELOAD = HW'(HOLDOFF - 1);

  logic [PW-1:0] pre_q, pre_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          pend_q, pend_d;
  logic          tick_q, tick_d;
  logic          valid_q, valid_d;
  logic [23:0]   data_q, data_d;
  logic [3:0]    ht_q, hu_q, mt_q, mu_q, st_q, su_q;
  logic [3:0]    ht_d, hu_d, mt_d, mu_d, st_d, su_d;

  logic raw_tick, any_set, tick, carry_m, carry_h, step_m, step_h;
  logic update, publish;

  always_comb begin
    raw_tick = (pre_q == PRE_MAX);
    any_set  = i_INC_H | i_INC_M | i_CLR_S;
    tick     = raw_tick & ~i_CLR_S;
    // A set pulse landing on a tick suppresses the tick's carries out of seconds.
    carry_m  = tick & ~any_set & (st_q == 4'd5) & (su_q == 4'd9);
    carry_h  = carry_m & (mt_q == 4'd5) & (mu_q == 4'd9);
    step_m   = i_INC_M | carry_m;
    step_h   = i_INC_H | carry_h;
    update   = raw_tick | any_set;
    publish  = pend_q & (hold_q == '0);
  end

  always_comb begin
    pre_d = pre_q + PW'(1);
    if (i_CLR_S || raw_tick) pre_d = '0;
  end

  always_comb begin
    st_d = st_q;
    su_d = su_q;
    if (i_CLR_S) begin
      st_d = 4'd0;
      su_d = 4'd0;
    end else if (tick) begin
      if (su_q == 4'd9) begin
        su_d = 4'd0;
        st_d = (st_q == 4'd5) ? 4'd0 : st_q + 4'd1;
      end else begin
        su_d = su_q + 4'd1;
      end
    end
  end

  always_comb begin
    mt_d = mt_q;
    mu_d = mu_q;
    if (step_m) begin
      if (mu_q == 4'd9) begin
        mu_d = 4'd0;
        mt_d = (mt_q == 4'd5) ? 4'd0 : mt_q + 4'd1;
      end else begin
        mu_d = mu_q + 4'd1;
      end
    end
  end

  always_comb begin
    ht_d = ht_q;
    hu_d = hu_q;
    if (step_h) begin
      if (ht_q == 4'd2 && hu_q == 4'd3) begin
        ht_d = 4'd0;
        hu_d = 4'd0;
      end else if (hu_q == 4'd9) begin
        hu_d = 4'd0;
        ht_d = ht_q + 4'd1;
      end else begin
        hu_d = hu_q + 4'd1;
      end
    end
  end

  // Updates during holdoff just keep pending set, so one strobe carries the latest time.
  always_comb begin
    pend_d  = update | (pend_q & ~publish);
    hold_d  = hold_q;
    if (publish)             hold_d = HOLD_RELOAD;
    else if (hold_q != '0)   hold_d = hold_q - HW'(1);
    data_d  = publish ? {ht_q, hu_q, mt_q, mu_q, st_q, su_q} : data_q;
    valid_d = publish;
    tick_d  = tick;
  end

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      pre_q   <= '0;
      hold_q  <= '0;
      pend_q  <= 1'b1;
      tick_q  <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
      ht_q    <= 4'd0;
      hu_q    <= 4'd0;
      mt_q    <= 4'd0;
      mu_q    <= 4'd0;
      st_q    <= 4'd0;
      su_q    <= 4'd0;
    end else begin
      pre_q   <= pre_d;
      hold_q  <= hold_d;
      pend_q  <= pend_d;
      tick_q  <= tick_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      ht_q    <= ht_d;
      hu_q    <= hu_d;
      mt_q    <= mt_d;
      mu_q    <= mu_d;
      st_q    <= st_d;
      su_q    <= su_d;
    end
  end

  assign o_DATA  = data_q;
  assign o_VALID = valid_q;
  assign o_TICK  = tick_q;

endmodule
